// File: rtl/alu_serial_rx_if.sv
// Serial command link between a frame sender and the ALU receiver.
// The receiver takes the slave modport; the frame source takes master.
interface alu_serial_rx_if #(
    parameter int unsigned DATA_W = 32
);
    logic              sin;
    logic              out_valid;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [2:0]        op;
    logic [3:0]        err;

    modport master (
        output sin,
        input  out_valid, a, b, op, err
    );

    modport slave (
        input  sin,
        output out_valid, a, b, op, err
    );
endinterface

// File: rtl/alu_serial_rx.sv
// Receiver for the ALU serial command link: deserialises 11-bit frames, assembles {B,A},
// decodes the opcode, checks a serially accumulated CRC4 and issues one strobe per command.
module alu_serial_rx #(
    parameter int unsigned DATA_W  = 32,
    parameter bit          CHK_CRC = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_serial_rx_if.slave link_io
);

    localparam int unsigned NB = DATA_W / 8;
    localparam int unsigned KW = $clog2(2 * NB + 1);
    localparam logic [KW-1:0] KMax = KW'(2 * NB);

    typedef enum logic [2:0] {StIdle, StType, StBits, StStop, StHunt} state_e;

    state_e              state_q, state_d;
    logic                type_q, type_d;
    logic [2:0]          idx_q, idx_d;
    logic [7:0]          byte_q, byte_d;
    logic [3:0]          crc_tmp_q, crc_tmp_d;
    logic [3:0]          crc_q, crc_d;
    logic [2*DATA_W-1:0] sr_q, sr_d;
    logic [KW-1:0]       k_q, k_d;
    logic                err_frame_q, err_frame_d;
    logic                err_data_q, err_data_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [2:0]          op_q, op_d;
    logic [3:0]          err_q, err_d;

    logic       sin;
    logic [2:0] op_rx;
    logic       data_bad;
    logic       op_bad;
    logic       crc_bad;

    function automatic logic [3:0] crc_step(input logic [3:0] c, input logic d);
        logic fb;
        fb = c[3] ^ d;
        return {c[2], c[1], c[0] ^ fb, fb};
    endfunction

    assign sin      = link_io.sin;
    assign op_rx    = byte_q[6:4];
    assign data_bad = err_data_q | (k_q != KMax);
    assign op_bad   = !(op_rx inside {3'b000, 3'b001, 3'b100, 3'b101});
    assign crc_bad  = CHK_CRC && !data_bad && (byte_q[3:0] != crc_tmp_q);

    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        idx_d       = idx_q;
        byte_d      = byte_q;
        crc_tmp_d   = crc_tmp_q;
        crc_d       = crc_q;
        sr_d        = sr_q;
        k_d         = k_q;
        err_frame_d = err_frame_q;
        err_data_d  = err_data_q;
        valid_d     = 1'b0;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        err_d       = err_q;

        case (state_q)
            StIdle: begin
                if (!sin) state_d = StType;
            end
            StType: begin
                type_d    = sin;
                idx_d     = 3'd7;
                crc_tmp_d = crc_q;
                state_d   = StBits;
            end
            StBits: begin
                byte_d = {byte_q[6:0], sin};
                // Ctl frames feed a constant 1 in place of the spare bit, then op; CRC bits skipped
                if (!type_q) begin
                    crc_tmp_d = crc_step(crc_tmp_q, sin);
                end else if (idx_q == 3'd7) begin
                    crc_tmp_d = crc_step(crc_tmp_q, 1'b1);
                end else if (idx_q[2]) begin
                    crc_tmp_d = crc_step(crc_tmp_q, sin);
                end
                idx_d = idx_q - 3'd1;
                if (idx_q == 3'd0) state_d = StStop;
            end
            StStop: begin
                if (sin) begin
                    state_d = StIdle;
                    if (!type_q) begin
                        if (k_q < KMax) begin
                            sr_d  = {sr_q[2*DATA_W-9:0], byte_q};
                            k_d   = k_q + KW'(1);
                            crc_d = crc_tmp_q;
                        end else begin
                            err_data_d = 1'b1;
                        end
                    end else begin
                        valid_d     = 1'b1;
                        a_d         = sr_q[DATA_W-1:0];
                        b_d         = sr_q[2*DATA_W-1:DATA_W];
                        op_d        = op_rx;
                        err_d       = {err_frame_q, data_bad, crc_bad, op_bad};
                        k_d         = '0;
                        crc_d       = 4'h0;
                        err_frame_d = 1'b0;
                        err_data_d  = 1'b0;
                    end
                end else begin
                    err_frame_d = 1'b1;
                    state_d     = StHunt;
                end
            end
            StHunt: begin
                if (sin) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            type_q      <= 1'b0;
            idx_q       <= 3'd0;
            byte_q      <= 8'h00;
            crc_tmp_q   <= 4'h0;
            crc_q       <= 4'h0;
            sr_q        <= '0;
            k_q         <= '0;
            err_frame_q <= 1'b0;
            err_data_q  <= 1'b0;
            valid_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= 3'd0;
            err_q       <= 4'h0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            idx_q       <= idx_d;
            byte_q      <= byte_d;
            crc_tmp_q   <= crc_tmp_d;
            crc_q       <= crc_d;
            sr_q        <= sr_d;
            k_q         <= k_d;
            err_frame_q <= err_frame_d;
            err_data_q  <= err_data_d;
            valid_q     <= valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            err_q       <= err_d;
        end
    end

    assign link_io.out_valid = valid_q;
    assign link_io.a         = a_q;
    assign link_io.b         = b_q;
    assign link_io.op        = op_q;
    assign link_io.err       = err_q;

endmodule

// File: tb/tb_alu_serial_rx.sv
// Directed bench for alu_serial_rx: three receivers (8/32/64-bit operands) on one clock,
// each with its own serial line; expectations come from constants and a CRC4 long division.
module tb_alu_serial_rx;

    localparam logic [2:0] OpAdd = 3'b100;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_serial_rx_if #(.DATA_W(8))  if8 ();
    alu_serial_rx_if #(.DATA_W(32)) if32 ();
    alu_serial_rx_if #(.DATA_W(64)) if64 ();

    alu_serial_rx #(.DATA_W(8), .CHK_CRC(1'b1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .link_io(if8)
    );
    alu_serial_rx #(.DATA_W(32), .CHK_CRC(1'b1)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .link_io(if32)
    );
    alu_serial_rx #(.DATA_W(64), .CHK_CRC(1'b1)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .link_io(if64)
    );

    int checks   = 0;
    int failures = 0;

    int          cnt     [3] = '{0, 0, 0};
    logic [63:0] cap_a   [3];
    logic [63:0] cap_b   [3];
    logic [2:0]  cap_op  [3];
    logic [3:0]  cap_err [3];

    always @(negedge clk) begin
        if (if8.out_valid) begin
            cnt[0] <= cnt[0] + 1;
            cap_a[0] <= 64'(if8.a);   cap_b[0] <= 64'(if8.b);
            cap_op[0] <= if8.op;      cap_err[0] <= if8.err;
        end
        if (if32.out_valid) begin
            cnt[1] <= cnt[1] + 1;
            cap_a[1] <= 64'(if32.a);  cap_b[1] <= 64'(if32.b);
            cap_op[1] <= if32.op;     cap_err[1] <= if32.err;
        end
        if (if64.out_valid) begin
            cnt[2] <= cnt[2] + 1;
            cap_a[2] <= if64.a;       cap_b[2] <= if64.b;
            cap_op[2] <= if64.op;     cap_err[2] <= if64.err;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // CRC4 x^4+x+1 by polynomial long division of {B,A,1,op} * x^4
    function automatic logic [3:0] crc_ref(input logic [63:0] a, input logic [63:0] b,
                                           input logic [2:0] op, input int w);
        logic [135:0] v;
        v = '0;
        for (int i = 0; i < 3; i++) v[4+i] = op[i];
        v[7] = 1'b1;
        for (int i = 0; i < w; i++) begin
            v[8+i]   = a[i];
            v[8+w+i] = b[i];
        end
        for (int i = 2 * w + 7; i >= 4; i--) begin
            if (v[i]) v[i-:5] = v[i-:5] ^ 5'b10011;
        end
        return v[3:0];
    endfunction

    task automatic drive(input int sel, input logic v);
        @(negedge clk);
        case (sel)
            0:       if8.sin = v;
            1:       if32.sin = v;
            default: if64.sin = v;
        endcase
    endtask

    task automatic idle(input int sel, input int n);
        repeat (n) drive(sel, 1'b1);
    endtask

    task automatic send_frame(input int sel, input logic typ, input logic [7:0] d,
                              input logic stop);
        drive(sel, 1'b0);
        drive(sel, typ);
        for (int i = 7; i >= 0; i--) drive(sel, d[i]);
        drive(sel, stop);
    endtask

    function automatic logic [7:0] op_byte(input logic [63:0] a, input logic [63:0] b, input int w,
                                           input int j);
        logic [127:0] ba;
        logic [127:0] t;
        ba = '0;
        for (int i = 0; i < w; i++) begin
            ba[i]   = a[i];
            ba[w+i] = b[i];
        end
        t = ba >> (8 * (w / 4 - 1 - j));
        return t[7:0];
    endfunction

    // ndata data frames (bytes of {B,A} MSB first, 8'hA5 beyond), then the ctl frame
    task automatic send_cmd(input int sel, input int w, input logic [63:0] a,
                            input logic [63:0] b, input logic [2:0] op,
                            input logic [3:0] crc_x, input int ndata);
        for (int j = 0; j < ndata; j++) begin
            send_frame(sel, 1'b0, (j < w / 4) ? op_byte(a, b, w, j) : 8'hA5, 1'b1);
        end
        send_frame(sel, 1'b1, {1'b0, op, crc_ref(a, b, op, w) ^ crc_x}, 1'b1);
        idle(sel, 3);
    endtask

    task automatic check_out(input int sel, input string tag, input int n0,
                             input logic [3:0] exp_err, input logic [2:0] exp_op,
                             input bit chk_ab, input logic [63:0] exp_a,
                             input logic [63:0] exp_b);
        check({tag, ".strobes"}, 64'(cnt[sel]), 64'(n0 + 1));
        check({tag, ".err"}, 64'(cap_err[sel]), 64'(exp_err));
        check({tag, ".op"}, 64'(cap_op[sel]), 64'(exp_op));
        if (chk_ab) begin
            check({tag, ".a"}, cap_a[sel], exp_a);
            check({tag, ".b"}, cap_b[sel], exp_b);
        end
    endtask

    initial begin
        int n0;
        rst_n    = 1'b1;
        if8.sin  = 1'b1;
        if32.sin = 1'b1;
        if64.sin = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset.valid", 64'(if32.out_valid), 64'd0);
        check("reset.a", 64'(if32.a), 64'd0);
        check("reset.b", 64'(if32.b), 64'd0);
        check("reset.op", 64'(if32.op), 64'd0);
        check("reset.err", 64'(if32.err), 64'd0);
        rst_n = 1'b1;
        idle(1, 2);

        // T1: good ADD
        n0 = cnt[1];
        send_cmd(1, 32, 64'd3, 64'd5, OpAdd, 4'h0, 8);
        check_out(1, "t1", n0, 4'b0000, OpAdd, 1'b1, 64'd3, 64'd5);

        // T2: corrupted CRC
        n0 = cnt[1];
        send_cmd(1, 32, 64'd3, 64'd5, OpAdd, 4'h1, 8);
        check_out(1, "t2", n0, 4'b0010, OpAdd, 1'b1, 64'd3, 64'd5);

        // T3: one byte short, then a good command clears the sticky flags
        n0 = cnt[1];
        send_cmd(1, 32, 64'd3, 64'd5, OpAdd, 4'h0, 7);
        check_out(1, "t3.short", n0, 4'b0100, OpAdd, 1'b0, 64'd0, 64'd0);
        n0 = cnt[1];
        send_cmd(1, 32, 64'd3, 64'd5, OpAdd, 4'h0, 8);
        check_out(1, "t3.next", n0, 4'b0000, OpAdd, 1'b1, 64'd3, 64'd5);

        // T4: illegal opcode with matching CRC
        n0 = cnt[1];
        send_cmd(1, 32, 64'd3, 64'd5, 3'b111, 4'h0, 8);
        check_out(1, "t4", n0, 4'b0001, 3'b111, 1'b1, 64'd3, 64'd5);

        // Ctl frame with no data frames
        n0 = cnt[1];
        send_cmd(1, 32, 64'd3, 64'd5, OpAdd, 4'h0, 0);
        check_out(1, "nodata", n0, 4'b0100, OpAdd, 1'b1, 64'd3, 64'd5);

        // T5: 3rd byte has a bad stop bit and a long low; 7 bytes land on top of old sr[7:0]=03
        n0 = cnt[1];
        for (int j = 0; j < 8; j++) begin
            if (j == 2) begin
                send_frame(1, 1'b0, op_byte(64'hDEADBEEF, 64'h0BADF00D, 32, j), 1'b0);
                repeat (5) drive(1, 1'b0);
                idle(1, 2);
            end else begin
                send_frame(1, 1'b0, op_byte(64'hDEADBEEF, 64'h0BADF00D, 32, j), 1'b1);
            end
        end
        send_frame(1, 1'b1, {1'b0, OpAdd, crc_ref(64'hDEADBEEF, 64'h0BADF00D, OpAdd, 32)}, 1'b1);
        idle(1, 3);
        check_out(1, "t5", n0, 4'b1100, OpAdd, 1'b1, 64'hDEADBEEF, 64'h030BAD0D);
        n0 = cnt[1];
        send_cmd(1, 32, 64'hDEADBEEF, 64'h0BADF00D, 3'b101, 4'h0, 8);
        check_out(1, "t5.next", n0, 4'b0000, 3'b101, 1'b1, 64'hDEADBEEF, 64'h0BADF00D);

        // T6: reset in the middle of the 5th data byte
        n0 = cnt[1];
        for (int j = 0; j < 4; j++) send_frame(1, 1'b0, 8'h5A, 1'b1);
        drive(1, 1'b0);
        drive(1, 1'b0);
        drive(1, 1'b1);
        drive(1, 1'b0);
        @(negedge clk);
        rst_n    = 1'b0;
        if32.sin = 1'b1;
        repeat (2) @(negedge clk);
        check("t6.rst.a", 64'(if32.a), 64'd0);
        check("t6.rst.err", 64'(if32.err), 64'd0);
        rst_n = 1'b1;
        idle(1, 4);
        check("t6.no_strobe", 64'(cnt[1]), 64'(n0));
        n0 = cnt[1];
        send_cmd(1, 32, 64'd3, 64'd5, OpAdd, 4'h0, 8);
        check_out(1, "t6.good", n0, 4'b0000, OpAdd, 1'b1, 64'd3, 64'd5);

        // T6: other operand widths
        n0 = cnt[0];
        send_cmd(0, 8, 64'd3, 64'd5, OpAdd, 4'h0, 2);
        check_out(0, "t6.w8", n0, 4'b0000, OpAdd, 1'b1, 64'd3, 64'd5);
        n0 = cnt[2];
        send_cmd(2, 64, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 3'b001, 4'h0, 16);
        check_out(2, "t6.w64", n0, 4'b0000, 3'b001, 1'b1,
                  64'h0123456789ABCDEF, 64'hFEDCBA9876543210);

        // Extra byte beyond 2*NB is dropped and flagged
        n0 = cnt[0];
        send_cmd(0, 8, 64'h3C, 64'hC3, 3'b000, 4'h0, 3);
        check_out(0, "w8.overflow", n0, 4'b0100, 3'b000, 1'b1, 64'h3C, 64'hC3);

        check("w8.total", 64'(cnt[0]), 64'd2);
        check("w64.total", 64'(cnt[2]), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
